// File: rtl/tqvp_pwm_pkg.sv
// tqvp_pwm_pkg: shared constants and helpers for the four-channel PWM peripheral.
// Register addresses, CTRL/FADE_CTRL bit positions and the fade step helper.
package tqvp_pwm_pkg;

    localparam int NUM_CH_MAX = 4;

    // Register map
    localparam logic [3:0] ADDR_CTRL      = 4'h0;
    localparam logic [3:0] ADDR_PRESCALE  = 4'h1;
    localparam logic [3:0] ADDR_PERIOD    = 4'h2;
    localparam logic [3:0] ADDR_STATUS    = 4'h3;
    localparam logic [3:0] ADDR_DUTY0     = 4'h4;
    localparam logic [3:0] ADDR_DUTY1     = 4'h5;
    localparam logic [3:0] ADDR_DUTY2     = 4'h6;
    localparam logic [3:0] ADDR_DUTY3     = 4'h7;
    localparam logic [3:0] ADDR_COUNT     = 4'h8;
    localparam logic [3:0] ADDR_FADE_STEP = 4'h9;
    localparam logic [3:0] ADDR_FADE_CTRL = 4'hA;

    // CTRL bit positions
    localparam int CTRL_RUN_BIT = 0;
    localparam int CTRL_INV_BIT = 1;
    localparam int CTRL_EN_LSB  = 4;

    // FADE_CTRL bit positions
    localparam int FADE_EN_BIT  = 0;
    localparam int FADE_DIR_BIT = 1;

    // Result of one fade step: new duty and whether it hit a rail
    typedef struct packed {
        logic       sat;
        logic [7:0] duty;
    } fade_res_t;

    // Move duty by step toward PERIOD+1 (up) or 0 (down), saturating at the rail.
    // PERIOD+1 = 256 cannot be stored, so the upper rail is clamped to 0xFF.
    function automatic fade_res_t fade_next(input logic [7:0] duty,
                                            input logic [7:0] step,
                                            input logic [7:0] period,
                                            input logic       dir_up);
        fade_res_t  res;
        logic [8:0] sum;
        logic [8:0] limit;
        sum   = {1'b0, duty} + {1'b0, step};
        limit = {1'b0, period} + 9'd1;
        res.sat  = 1'b0;
        res.duty = duty;
        if (dir_up) begin
            if (sum >= limit) begin
                res.sat  = 1'b1;
                res.duty = limit[8] ? 8'hFF : limit[7:0];
            end else begin
                res.duty = sum[7:0];
            end
        end else begin
            if (duty <= step) begin
                res.sat  = 1'b1;
                res.duty = 8'h00;
            end else begin
                res.duty = duty - step;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tqvp_pwm_quad_channel.sv
// pwm_channel: one PWM channel with double-buffered duty and registered output.
// The shadow register is CPU-visible; the active register feeds the compare and
// only follows the shadow at a period wrap (or continuously while stopped).
module pwm_channel
    import tqvp_pwm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_shadow_we,
    input  logic [W-1:0] i_shadow_d,
    input  logic         i_run,
    input  logic         i_en,
    input  logic         i_invert,
    input  logic         i_wrap,
    input  logic [W-1:0] i_count,
    output logic [W-1:0] o_shadow,
    output logic         o_pwm
);

    logic [W-1:0] r_shadow;
    logic [W-1:0] r_active;
    logic         r_pwm;
    logic         w_cmp;

    assign w_cmp = i_run & i_en & (i_count < r_active);

    // Shadow duty: written by the CPU (or the fade engine); reset wins over a write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (i_shadow_we) begin
            r_shadow <= i_shadow_d;
        end
    end

    // Active duty: tracks shadow while stopped, otherwise reloads only on wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= '0;
        end else if (!i_run || i_wrap) begin
            r_active <= r_shadow;
        end
    end

    // Registered compare output, so the pin lags the counter by one clock
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= i_invert ^ w_cmp;
        end
    end

    assign o_shadow = r_shadow;
    assign o_pwm    = r_pwm;

endmodule

// File: rtl/tqvp_pwm_quad.sv
// tqvp_pwm_quad: four-channel 8-bit PWM byte peripheral for the TinyQV harness.
// Shared prescaler and period counter, per-channel double-buffered duty,
// sticky wrap flag and a one-clock wrap strobe on uo_out[4].
// Optional triangle fade of DUTY0 is built when TQVP_PWM_FADE_EN is defined.
// CNT_W is tied to the byte-wide register map and must stay 8.
module tqvp_pwm_quad
    import tqvp_pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    // Control / configuration registers
    logic             r_run;
    logic             r_invert;
    logic [3:0]       r_ch_en;
    logic [CNT_W-1:0] r_prescale;
    logic [CNT_W-1:0] r_period;

    // Timebase
    logic [CNT_W-1:0] r_presc_cnt;
    logic [CNT_W-1:0] r_count;

    // Status and strobe
    logic             r_wrap_flag;
    logic             r_wrap_strobe;

    logic             w_hold;
    logic             w_tick;
    logic             w_wrap;
    logic [3:0]       w_ch_mask;
    logic [3:0]       w_pwm;
    logic [CNT_W-1:0] w_shadow [NUM_CH_MAX];
    logic             w_cpu_duty0;
    logic             w_duty0_we;
    logic [CNT_W-1:0] w_duty0_d;
    logic [7:0]       w_rdata;
    logic             w_unused;

    assign w_unused = &{1'b0, ui_in[7:1]};

    assign w_hold = ui_in[0];
    assign w_tick = r_run & ~w_hold & (r_presc_cnt == r_prescale);
    // A count above a freshly lowered PERIOD runs on to 0xFF and rolls over there
    assign w_wrap = w_tick & ((r_count == r_period) | (r_count == {CNT_W{1'b1}}));

    assign w_cpu_duty0 = data_write & (address == ADDR_DUTY0);

    // CPU writes to CTRL / PRESCALE / PERIOD
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_invert   <= 1'b0;
            r_ch_en    <= 4'h0;
            r_prescale <= '0;
            r_period   <= {CNT_W{1'b1}};
        end else if (data_write) begin
            case (address)
                ADDR_CTRL: begin
                    r_run    <= data_in[CTRL_RUN_BIT];
                    r_invert <= data_in[CTRL_INV_BIT];
                    r_ch_en  <= data_in[CTRL_EN_LSB +: 4] & w_ch_mask;
                end
                ADDR_PRESCALE: r_prescale <= data_in;
                ADDR_PERIOD:   r_period   <= data_in;
                default: ;
            endcase
        end
    end

    // Prescaler and period counter: cleared while stopped, frozen while held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc_cnt <= '0;
            r_count     <= '0;
        end else if (!r_run) begin
            r_presc_cnt <= '0;
            r_count     <= '0;
        end else if (!w_hold) begin
            if (r_presc_cnt == r_prescale) begin
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= r_presc_cnt + 1'b1;
            end
            if (w_tick) begin
                r_count <= w_wrap ? '0 : r_count + 1'b1;
            end
        end
    end

    // Sticky wrap flag; a wrap in the same cycle as a W1C keeps the flag set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrap_flag <= 1'b0;
        end else if (w_wrap) begin
            r_wrap_flag <= 1'b1;
        end else if (data_write && (address == ADDR_STATUS) && data_in[0]) begin
            r_wrap_flag <= 1'b0;
        end
    end

    // One-clock registered wrap strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrap_strobe <= 1'b0;
        end else begin
            r_wrap_strobe <= w_wrap;
        end
    end

`ifdef TQVP_PWM_FADE_EN
    logic [7:0] r_fade_step;
    logic       r_fade_en;
    logic       r_fade_dir;
    fade_res_t  w_fade;
    logic       w_fade_apply;

    assign w_fade       = fade_next(w_shadow[0], r_fade_step, r_period, r_fade_dir);
    assign w_fade_apply = w_wrap & r_fade_en;
    // A CPU write to DUTY0 takes priority over the fade step in the same cycle
    assign w_duty0_we   = w_cpu_duty0 | w_fade_apply;
    assign w_duty0_d    = w_cpu_duty0 ? data_in : w_fade.duty;

    // Fade step size, enable and direction; direction flips when a rail is hit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fade_step <= 8'h01;
            r_fade_en   <= 1'b0;
            r_fade_dir  <= 1'b0;
        end else begin
            if (data_write && (address == ADDR_FADE_STEP)) begin
                r_fade_step <= data_in;
            end
            if (data_write && (address == ADDR_FADE_CTRL)) begin
                r_fade_en  <= data_in[FADE_EN_BIT];
                r_fade_dir <= data_in[FADE_DIR_BIT];
            end else if (w_fade_apply && w_fade.sat) begin
                r_fade_dir <= ~r_fade_dir;
            end
        end
    end
`else
    assign w_duty0_we = w_cpu_duty0;
    assign w_duty0_d  = data_in;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH_MAX; gi++) begin : g_ch
            if (gi < NUM_CH) begin : g_on
                logic             w_we;
                logic [CNT_W-1:0] w_d;
                if (gi == 0) begin : g_first
                    assign w_we = w_duty0_we;
                    assign w_d  = w_duty0_d;
                end else begin : g_rest
                    assign w_we = data_write & (address == (ADDR_DUTY0 + 4'(gi)));
                    assign w_d  = data_in;
                end
                assign w_ch_mask[gi] = 1'b1;
                pwm_channel #(
                    .W (CNT_W)
                ) u_ch (
                    .clk         (clk),
                    .rst_n       (rst_n),
                    .i_shadow_we (w_we),
                    .i_shadow_d  (w_d),
                    .i_run       (r_run),
                    .i_en        (r_ch_en[gi]),
                    .i_invert    (r_invert),
                    .i_wrap      (w_wrap),
                    .i_count     (r_count),
                    .o_shadow    (w_shadow[gi]),
                    .o_pwm       (w_pwm[gi])
                );
            end else begin : g_off
                assign w_ch_mask[gi] = 1'b0;
                assign w_shadow[gi]  = '0;
                assign w_pwm[gi]     = 1'b0;
            end
        end
    endgenerate

    // Zero-latency register readback
    always_comb begin
        w_rdata = 8'h00;
        case (address)
            ADDR_CTRL:     w_rdata = {r_ch_en, 2'b00, r_invert, r_run};
            ADDR_PRESCALE: w_rdata = r_prescale;
            ADDR_PERIOD:   w_rdata = r_period;
            ADDR_STATUS:   w_rdata = {7'b0, r_wrap_flag};
            ADDR_DUTY0, ADDR_DUTY1, ADDR_DUTY2, ADDR_DUTY3:
                           w_rdata = w_shadow[address[1:0]];
            ADDR_COUNT:    w_rdata = r_count;
`ifdef TQVP_PWM_FADE_EN
            ADDR_FADE_STEP: w_rdata = r_fade_step;
            ADDR_FADE_CTRL: w_rdata = {6'b0, r_fade_dir, r_fade_en};
`endif
            default:       w_rdata = 8'h00;
        endcase
    end

    assign data_out = w_rdata;
    assign uo_out   = {3'b000, r_wrap_strobe, w_pwm};

endmodule
